// File: rtl/flip_flop_jk_bank.sv
// Bank of WIDTH JK flip-flops with JK/T/D modes and an optional up/down counter mode.
// Define FLIP_FLOP_JK_BANK_COUNT_EN to build COUNT mode (2'b11) and the terminal output.
module flip_flop_jk_bank #(
   parameter int unsigned      WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] jack,
   input  logic [WIDTH-1:0] kilby,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] notout,
   output logic             terminal
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;

`ifdef FLIP_FLOP_JK_BANK_COUNT_EN
   logic [WIDTH-1:0] dir_bits;
   logic [WIDTH-1:0] low_mask;
   logic [WIDTH-1:0] count_t;

   // Counting down is counting up on the inverted state, so one all-ones test serves both.
   always_comb begin
      dir_bits = kilby[0] ? ~state_q : state_q;
      low_mask = '0;
      count_t  = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         low_mask   = (WIDTH'(1) << i) - WIDTH'(1);
         count_t[i] = &(dir_bits | ~low_mask);
      end
   end

   assign terminal = enable & (mode == 2'b11) & (&dir_bits);
`else
   assign terminal = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      if (enable) begin
         unique case (mode)
            2'b00: state_d = (jack & ~state_q) | (~kilby & state_q);
            2'b01: state_d = state_q ^ jack;
            2'b10: state_d = jack;
            2'b11: begin
`ifdef FLIP_FLOP_JK_BANK_COUNT_EN
               state_d = state_q ^ count_t;
`else
               state_d = state_q;
`endif
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RESET_VALUE;
      end else begin
         state_q <= state_d;
      end
   end

   assign out    = state_q;
   assign notout = ~state_q;

endmodule

// File: tb/tb_flip_flop_jk_bank.sv
// Directed plus randomized bench for flip_flop_jk_bank against a behavioural model.
// The model follows FLIP_FLOP_JK_BANK_COUNT_EN the same way the design does.
module tb_flip_flop_jk_bank;

   localparam logic [3:0] RV = 4'b1010;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] mode;
   logic [3:0] jack;
   logic [3:0] kilby;
   logic [3:0] out;
   logic [3:0] notout;
   logic       terminal;

   logic [3:0] exp_q;
   int         tests = 0;
   int         fails = 0;

   flip_flop_jk_bank #(
      .WIDTH       (4),
      .RESET_VALUE (RV)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .mode     (mode),
      .jack     (jack),
      .kilby    (kilby),
      .out      (out),
      .notout   (notout),
      .terminal (terminal)
   );

   always #5 clock = ~clock;

   function automatic logic [3:0] model_next(logic [3:0] q, logic e, logic [1:0] m,
                                             logic [3:0] j, logic [3:0] k);
      logic [3:0] r;
      r = q;
      if (!e) return q;
      case (m)
         2'b00: begin
            for (int i = 0; i < 4; i++) begin
               case ({j[i], k[i]})
                  2'b01:   r[i] = 1'b0;
                  2'b10:   r[i] = 1'b1;
                  2'b11:   r[i] = ~q[i];
                  default: r[i] = q[i];
               endcase
            end
         end
         2'b01: r = q ^ j;
         2'b10: r = j;
         default: begin
`ifdef FLIP_FLOP_JK_BANK_COUNT_EN
            r = k[0] ? q - 4'd1 : q + 4'd1;
`else
            r = q;
`endif
         end
      endcase
      return r;
   endfunction

   function automatic logic model_term(logic [3:0] q, logic e, logic [1:0] m, logic [3:0] k);
`ifdef FLIP_FLOP_JK_BANK_COUNT_EN
      return e && (m == 2'b11) && (k[0] ? (q == 4'd0) : (q == 4'hF));
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string tag);
      logic et;
      et = model_term(exp_q, enable, mode, kilby);
      tests++;
      assert (out === exp_q) else begin
         fails++;
         $error("FAIL %s out=%b expected=%b", tag, out, exp_q);
      end
      tests++;
      assert (notout === ~exp_q) else begin
         fails++;
         $error("FAIL %s notout=%b expected=%b", tag, notout, ~exp_q);
      end
      tests++;
      assert (terminal === et) else begin
         fails++;
         $error("FAIL %s terminal=%b expected=%b", tag, terminal, et);
      end
   endtask

   task automatic check_const(input string tag, input logic [3:0] want);
      tests++;
      assert (out === want) else begin
         fails++;
         $error("FAIL %s out=%b expected=%b", tag, out, want);
      end
   endtask

   task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] j,
                        input logic [3:0] k, input string tag);
      enable = e;
      mode   = m;
      jack   = j;
      kilby  = k;
      #1;
      check(tag);
   endtask

   task automatic tick(input string tag);
      if (!reset) exp_q = model_next(exp_q, enable, mode, jack, kilby);
      @(posedge clock);
      #1;
      check(tag);
   endtask

   task automatic pulse_reset(input string tag);
      reset = 1'b1;
      #1;
      exp_q = RV;
      check(tag);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      mode   = 2'b00;
      jack   = 4'b0000;
      kilby  = 4'b0000;
      exp_q  = RV;
      #1;
      check("reset_state");
      check_const("reset_value", RV);
      @(posedge clock);
      #1;
      check("reset_hold");
      reset = 1'b0;

      // Reset in the middle of counting
      drive(1'b1, 2'b10, 4'b0000, 4'b0000, "load0");
      tick("load0_edge");
      drive(1'b1, 2'b11, 4'b0000, 4'b0000, "cnt_up_sel");
      tick("cnt1");
      tick("cnt2");
      tick("cnt3");
      #2;
      pulse_reset("mid_reset");
      check_const("mid_reset_val", RV);
      drive(1'b1, 2'b10, 4'b0101, 4'b0000, "reset_drive");
      tick("edge_in_reset1");
      tick("edge_in_reset2");
      check_const("reset_holds", RV);
      reset = 1'b0;

      // JK truth table
      drive(1'b1, 2'b10, 4'b0101, 4'b0000, "jk_load");
      tick("jk_load_edge");
      drive(1'b1, 2'b00, 4'b1100, 4'b1010, "jk_sel");
      tick("jk_edge");
      check_const("jk_result", 4'b1101);

      // T, D and enable
      drive(1'b1, 2'b10, 4'b0000, 4'b0000, "t_load");
      tick("t_load_edge");
      drive(1'b1, 2'b01, 4'b1001, 4'b1111, "t_sel");
      tick("t_edge");
      check_const("t_result", 4'b1001);
      drive(1'b1, 2'b10, 4'b0110, 4'b1111, "d_sel");
      tick("d_edge");
      check_const("d_result", 4'b0110);
      drive(1'b0, 2'b10, 4'b1111, 4'b0000, "en_off");
      tick("en_off_edge");
      check_const("en_off_hold", 4'b0110);

      // Count up across the wrap
      drive(1'b1, 2'b10, 4'b1110, 4'b0000, "up_load");
      tick("up_load_edge");
      drive(1'b1, 2'b11, 4'b0000, 4'b0000, "up_1110");
      tick("up_1111");
      tick("up_wrap");
      tick("up_after");

      // Count down across the wrap, then reverse
      drive(1'b1, 2'b10, 4'b0001, 4'b0000, "dn_load");
      tick("dn_load_edge");
      drive(1'b1, 2'b11, 4'b0000, 4'b0001, "dn_0001");
      tick("dn_0000");
      tick("dn_wrap");
      drive(1'b1, 2'b11, 4'b0000, 4'b0000, "dn_flip");
      tick("dn_flip_edge");

      // COUNT mode with other inputs noisy, five edges from 0011
      drive(1'b1, 2'b10, 4'b0011, 4'b0000, "m11_load");
      tick("m11_load_edge");
      drive(1'b1, 2'b11, 4'b1111, 4'b1110, "m11_sel");
      for (int i = 0; i < 5; i++) tick("m11_edge");

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rnd_pre");
         tick("rnd_edge");
         if ($urandom_range(0, 24) == 0) begin
            #2;
            pulse_reset("rnd_reset");
            tick("rnd_reset_edge");
            reset = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
